unsigned_seq_divider_16x8: RTL and testbench

Sequential unsigned restoring divider: 16-bit dividend ÷ 8-bit divisor → 16-bit quotient plus 8-bit remainder, one quotient bit per clock. It is the inverse-direction companion of the unsigned 8x8 multiplier family. It recovers an operand from a 16-bit product, and it serves as the exact reference datapath when characterising approximate multiplier error (z/y versus x). It sits behind a valid/ready request channel and in front of a valid/ready result channel.

---
 rtl/unsigned_div_pkg.sv | 17 +
 rtl/div_restore_step.sv | 28 ++
 rtl/unsigned_seq_divider_16x8.sv | 125 ++++++++++++
 tb/tb_unsigned_seq_divider_16x8.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_div_pkg.sv
// Shared types and constants for the sequential unsigned restoring divider.
// Holds the controller state encoding and the divide-by-zero quotient pattern.
package unsigned_div_pkg;

  localparam int DW     = 16;
  localparam int VW     = 8;
  localparam int ITER_W = $clog2(DW);

  localparam logic [DW-1:0] DIV0_QUOTIENT = {DW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// conditionally subtract the divisor and report the resulting quotient bit.
module div_restore_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] r,
  input  logic          q_msb,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] r_next,
  output logic          q_bit
);

  logic [VW:0] p;

  // Trial subtraction; the low VW bits of p - divisor are exact because the
  // true difference is always smaller than the divisor.
  always_comb begin
    p = {r, q_msb};
    if (p >= {1'b0, divisor}) begin
      r_next = p[VW-1:0] - divisor;
      q_bit  = 1'b1;
    end else begin
      r_next = p[VW-1:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/unsigned_seq_divider_16x8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// valid/ready request channel and a valid/ready result channel.
module unsigned_seq_divider_16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  import unsigned_div_pkg::*;

  localparam int ITW = $clog2(DW);

  state_t          state;
  state_t          state_next;
  logic [ITW-1:0]  iter;
  logic [DW-1:0]   q;
  logic [VW-1:0]   r;
  logic [VW-1:0]   dvsr;
  logic [VW-1:0]   r_next;
  logic            q_bit;
  logic            last_step;

  div_restore_step #(.VW(VW)) u_step (
    .r       (r),
    .q_msb   (q[DW-1]),
    .divisor (dvsr),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  assign last_step = (state == BUSY) && (iter == ITW'(DW - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next-state decode; a zero divisor bypasses the iteration phase.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (divisor == {VW{1'b0}}) ? DONE : BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_next = DONE;
        end else begin
          state_next = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter        <= '0;
      q           <= '0;
      r           <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q           <= dividend;
            r           <= '0;
            dvsr        <= divisor;
            iter        <= '0;
            div_by_zero <= (divisor == {VW{1'b0}});
            if (divisor == {VW{1'b0}}) begin
              quotient  <= DIV0_QUOTIENT;
              remainder <= dividend[VW-1:0];
            end
          end
        end
        BUSY: begin
          q    <= {q[DW-2:0], q_bit};
          r    <= r_next;
          iter <= iter + ITW'(1);
          if (last_step) begin
            quotient  <= {q[DW-2:0], q_bit};
            remainder <= r_next;
          end
        end
        default: begin
          iter <= iter;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_divider_16x8.sv
// Self-checking bench for unsigned_seq_divider_16x8: directed cases, handshake
// and reset scenarios, and randomized operands against an arithmetic model.
module tb_unsigned_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  unsigned_seq_divider_16x8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, with the defined divide-by-zero result.
  function automatic void ref_div(input logic [15:0] dd, input logic [7:0] dv,
                                  output logic [15:0] eq, output logic [7:0] er,
                                  output logic ez);
    if (dv == 8'd0) begin
      eq = 16'hFFFF;
      er = dd[7:0];
      ez = 1'b1;
    end else begin
      eq = dd / {8'd0, dv};
      er = 8'(dd % {8'd0, dv});
      ez = 1'b0;
    end
  endfunction

  // Present one request; returns #1 after the accept edge.
  task automatic start_req(input logic [15:0] dd, input logic [7:0] dv);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_req_in_ready got=%b exp=1", in_ready);
    end
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Run a full transaction: accept, wait (bounded) for the result, handshake it.
  task automatic run_one(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic z, output int lat);
    start_req(dd, dv);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b1;
    dividend  = 16'h5555;
    divisor   = 8'h03;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'h0000 ||
        remainder !== 8'h00 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0000 r=00 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] dds [5] = '{16'hFE01, 16'h03E8, 16'hFFFF, 16'h1234, 16'h0010};
    logic [7:0]  dvs [5] = '{8'hFF, 8'h07, 8'h01, 8'h00, 8'h04};
    logic [15:0] q, eq;
    logic [7:0]  r, er;
    logic        z, ez;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      ref_div(dds[i], dvs[i], eq, er, ez);
      run_one(dds[i], dvs[i], q, r, z, lat);
      checks++;
      if (q !== eq || r !== er || z !== ez) begin
        errors++;
        $display("FAIL directed_%0d got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, q, r, z, eq, er, ez);
      end
      checks++;
      if ((dvs[i] != 8'd0 && lat != 16) || (dvs[i] == 8'd0 && lat > 1)) begin
        errors++;
        $display("FAIL latency_%0d got=%0d exp=%0d", i, lat, (dvs[i] == 8'd0) ? 1 : 16);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL handshake_idle_%0d got rdy=%b vld=%b exp rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start_req(16'h03E8, 8'h07);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || quotient !== 16'h008E || remainder !== 8'h06 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL bp_result got vld=%b q=%h r=%h z=%b exp vld=1 q=008e r=06 z=0",
               out_valid, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'h008E || remainder !== 8'h06) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b q=%h r=%h exp vld=1 rdy=0 q=008e r=06",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    start_req(16'hABCD, 8'h13);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midbusy_state got vld=%b rdy=%b exp vld=0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'h0000 ||
        remainder !== 8'h00 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL midbusy_reset got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0000 r=00 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    run_one(16'hABCD, 8'h13, q, r, z, lat);
    checks++;
    if (q !== 16'h090A || r !== 8'h0F || z !== 1'b0 || lat != 16) begin
      errors++;
      $display("FAIL midbusy_rerun got q=%h r=%h z=%b lat=%0d exp q=090a r=0f z=0 lat=16", q, r, z, lat);
    end
  endtask

  task automatic test_random_inverse;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    int          x, y;
    for (int i = 0; i < 1500; i++) begin
      x = $urandom_range(1, 255);
      y = $urandom_range(1, 255);
      run_one(16'(x * y), 8'(y), q, r, z, lat);
      checks++;
      if (q !== 16'(x) || r !== 8'h00 || z !== 1'b0 || lat != 16) begin
        errors++;
        $display("FAIL inverse z=%0d y=%0d got q=%0d r=%0d dz=%b lat=%0d exp q=%0d r=0 dz=0 lat=16",
                 x * y, y, q, r, z, lat, x);
      end
    end
  endtask

  task automatic test_random_general;
    logic [15:0] q, eq, dd;
    logic [7:0]  r, er, dv;
    logic        z, ez;
    int          lat;
    for (int i = 0; i < 400; i++) begin
      dd = 16'($urandom);
      dv = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      ref_div(dd, dv, eq, er, ez);
      run_one(dd, dv, q, r, z, lat);
      checks++;
      if (q !== eq || r !== er || z !== ez) begin
        errors++;
        $display("FAIL random dd=%h dv=%h got q=%h r=%h z=%b exp q=%h r=%h z=%b", dd, dv, q, r, z, eq, er, ez);
      end
      if (dv != 8'd0) begin
        checks++;
        if ((32'(q) * 32'(dv) + 32'(r)) != 32'(dd) || r >= dv) begin
          errors++;
          $display("FAIL identity dd=%h dv=%h got q=%h r=%h exp q*dv+r=dd and r<dv", dd, dv, q, r);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'h0000;
    divisor   = 8'h00;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_random_inverse();
    test_random_general();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
